// File: rtl/dadda_8_bit_mul.sv
`default_nettype none
// ============================================================================
// Module      : dadda_8_bit_mul
// Description : Unsigned multiply-accumulate p = a*b + acc via a Dadda tree;
//               define DADDA_PIPE_EN for a register stage before the final add.
// Revision    : 1.0 - initial release
// ============================================================================
module dadda_8_bit_mul (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic [15:0] acc,
  input  logic        in_valid,
  output logic [16:0] p,
  output logic        out_valid
);

  logic [16:0] w_row0;
  logic [16:0] w_row1;
  logic [16:0] w_sum;
  logic        w_v;
  logic [16:0] r_p;
  logic        r_v;

  // Column heights are data-independent, so every loop here unrolls into a
  // fixed network of full and half adders.
  always_comb begin : p_dadda
    logic [8:0] m  [17];
    logic [8:0] nm [17];
    int         h  [17];
    int         nh [17];
    int         d;
    int         rem;
    int         idx;
    logic       x;
    logic       y;
    logic       z;
    logic       zi;

    d   = 0;
    rem = 0;
    idx = 0;
    x   = 1'b0;
    y   = 1'b0;
    z   = 1'b0;
    zi  = 1'b0;
    w_row0 = '0;
    w_row1 = '0;
    for (int c = 0; c < 17; c++) begin
      m[c]  = '0;
      nm[c] = '0;
      h[c]  = 0;
      nh[c] = 0;
    end

    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        m[i+j][h[i+j]] = a[i] & b[j];
        h[i+j]         = h[i+j] + 1;
      end
    end
    for (int k = 0; k < 16; k++) begin
      m[k][h[k]] = acc[k];
      h[k]       = h[k] + 1;
    end

    // Stage targets 6, 4, 3, 2; carries from column c count toward c+1's height.
    for (int st = 0; st < 4; st++) begin
      d = (st == 0) ? 6 : (st == 1) ? 4 : (st == 2) ? 3 : 2;
      for (int c = 0; c < 17; c++) begin
        nm[c] = '0;
        nh[c] = 0;
      end
      for (int c = 0; c < 17; c++) begin
        rem = h[c];
        idx = 0;
        for (int t = 0; t < 9; t++) begin
          if (rem + nh[c] > d) begin
            x = m[c][idx];
            y = m[c][idx+1];
            if (rem + nh[c] == d + 1) begin
              nm[c][nh[c]] = x ^ y;
              z   = x & y;
              idx = idx + 2;
              rem = rem - 2;
            end else begin
              zi  = m[c][idx+2];
              nm[c][nh[c]] = x ^ y ^ zi;
              z   = (x & y) | (zi & (x ^ y));
              idx = idx + 3;
              rem = rem - 3;
            end
            nh[c] = nh[c] + 1;
            if (c < 16) begin
              nm[c+1][nh[c+1]] = z;
              nh[c+1]          = nh[c+1] + 1;
            end
          end
        end
        for (int t = 0; t < 9; t++) begin
          if (t < rem) begin
            nm[c][nh[c]] = m[c][idx+t];
            nh[c]        = nh[c] + 1;
          end
        end
      end
      for (int c = 0; c < 17; c++) begin
        m[c] = nm[c];
        h[c] = nh[c];
      end
    end

    for (int c = 0; c < 17; c++) begin
      w_row0[c] = m[c][0];
      w_row1[c] = m[c][1];
    end
  end

`ifdef DADDA_PIPE_EN
  logic [16:0] r_row0;
  logic [16:0] r_row1;
  logic        r_v1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row0 <= '0;
      r_row1 <= '0;
      r_v1   <= 1'b0;
    end else begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_row0 <= w_row0;
        r_row1 <= w_row1;
      end
    end
  end

  assign w_sum = r_row0 + r_row1;
  assign w_v   = r_v1;
`else
  assign w_sum = w_row0 + w_row1;
  assign w_v   = in_valid;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p <= '0;
      r_v <= 1'b0;
    end else begin
      r_v <= w_v;
      if (w_v) begin
        r_p <= w_sum;
      end
    end
  end

  assign p         = r_p;
  assign out_valid = r_v;

endmodule
`default_nettype wire

// File: tb/tb_dadda_8_bit_mul.sv
`default_nettype none
// ============================================================================
// Module      : tb_dadda_8_bit_mul
// Description : Self-checking bench for dadda_8_bit_mul (either DADDA_PIPE_EN setting).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dadda_8_bit_mul;

`ifdef DADDA_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] acc;
  logic        in_valid;
  logic [16:0] p;
  logic        out_valid;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  dadda_8_bit_mul dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .acc       (acc),
    .in_valid  (in_valid),
    .p         (p),
    .out_valid (out_valid)
  );

  // Reference: a delay line of (valid, a*b+acc) samples, LAT deep.
  logic        q_v [LAT];
  logic [16:0] q_s [LAT];
  logic [16:0] held;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        q_v[i] <= 1'b0;
        q_s[i] <= '0;
      end
    end else begin
      for (int i = LAT - 1; i > 0; i--) begin
        q_v[i] <= q_v[i-1];
        q_s[i] <= q_s[i-1];
      end
      q_v[0] <= in_valid;
      q_s[0] <= 17'(a) * 17'(b) + 17'(acc);
    end
  end

  task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      held = '0;
    end else begin
      if (q_v[LAT-1]) held = q_s[LAT-1];
      check("out_valid", {16'b0, out_valid}, {16'b0, q_v[LAT-1]});
      check("p", p, held);
    end
  end

  task automatic lit(input string name, input logic [7:0] ta, input logic [7:0] tb_,
                     input logic [15:0] tacc, input logic [16:0] exp);
    @(negedge clk);
    a = ta; b = tb_; acc = tacc; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (LAT - 1) @(negedge clk);
    check(name, p, exp);
    check({name, "_valid"}, {16'b0, out_valid}, 17'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; a = '0; b = '0; acc = '0; in_valid = 1'b0;
    #12;
    check("reset_p", p, 17'h0);
    check("reset_valid", {16'b0, out_valid}, 17'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    lit("max_mix", 8'hFF, 8'hFF, 16'h0F0F, 17'h10D10);
    lit("max_all", 8'hFF, 8'hFF, 16'hFFFF, 17'h1FE00);
    lit("a_zero",  8'h00, 8'hA5, 16'h1234, 17'h01234);
    lit("small",   8'h0C, 8'h0D, 16'h0000, 17'h0009C);

    // Back-to-back stream with a single-cycle gap.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      a = 8'($urandom); b = 8'($urandom); acc = 16'($urandom);
      in_valid = (i != 7);
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (LAT + 1) @(negedge clk);

    // Asynchronous reset in the middle of a stream.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a = 8'hF0 | 8'(i); b = 8'hE7; acc = 16'hBEEF; in_valid = 1'b1;
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check("async_rst_p", p, 17'h0);
    check("async_rst_valid", {16'b0, out_valid}, 17'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT + 3) @(negedge clk);

    // Exhaustive operands with random addend.
    for (int ai = 0; ai < 256; ai++) begin
      for (int bi = 0; bi < 256; bi++) begin
        @(negedge clk);
        a = 8'(ai); b = 8'(bi); acc = 16'($urandom); in_valid = 1'b1;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (LAT + 2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
